// File: rtl/print_pkg.sv
// Shared types and ASCII constants for the printer scheduling path.
package print_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        WRAP_CR,
        WRAP_LF
    } state_t;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= ASCII_SP) && (b <= ASCII_TILDE);
    endfunction

endpackage

// File: rtl/char_fifo.sv
// Synchronous FIFO; a push alongside a pop is accepted even when full.
module char_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/print_scheduler.sv
// Buffers decoder bytes and feeds print_control one at a time over rdy/done.
// Optional hardware line wrap: define PRINT_SCHED_WRAP_EN.
module print_scheduler
    import print_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int LINE_W  = 80,
    parameter int TIMEOUT = 2**24
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        char_valid,
    input  logic [7:0]                  char_in,
    output logic                        prt_rdy,
    output logic [7:0]                  prt_ascii,
    input  logic                        prt_done,
    output logic                        busy,
    output logic [$clog2(DEPTH):0]      fifo_count,
    output logic [$clog2(LINE_W+1)-1:0] col,
    output logic                        overflow,
    output logic                        timeout_err
);
    localparam int CW = $clog2(LINE_W+1);
    localparam int TW = $clog2(TIMEOUT+1);

    state_t        state;
    logic [TW-1:0] timer;
    logic [7:0]    head;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_ok;

    function automatic logic [CW-1:0] col_next(input logic [CW-1:0] c, input logic [7:0] b);
        if (is_printable(b))
            return (c == CW'(LINE_W)) ? c : c + CW'(1);
        else if (b == ASCII_CR || b == ASCII_LF)
            return '0;
        else if (b == ASCII_BS)
            return (c == '0) ? c : c - CW'(1);
        else
            return c;
    endfunction

`ifdef PRINT_SCHED_WRAP_EN
    logic lf_pending;
    logic wrap_cond;
    // A printable byte landing past the last column is preceded by CR, LF.
    assign wrap_cond = is_printable(head) && (col == CW'(LINE_W));
    assign pop       = (state == IDLE) && !empty && !lf_pending && !wrap_cond;
`else
    assign pop       = (state == IDLE) && !empty;
`endif

    assign push_ok = char_valid && (!full || pop);

    char_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (char_valid),
        .pop   (pop),
        .din   (char_in),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            prt_rdy     <= 1'b0;
            prt_ascii   <= '0;
            busy        <= 1'b0;
            col         <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
`ifdef PRINT_SCHED_WRAP_EN
            lf_pending  <= 1'b0;
`endif
        end else begin
            if (char_valid && full && !pop) overflow <= 1'b1;

            case (state)
                IDLE: begin
                    busy <= push_ok;
`ifdef PRINT_SCHED_WRAP_EN
                    if (lf_pending) begin
                        state      <= WRAP_LF;
                        prt_rdy    <= 1'b1;
                        prt_ascii  <= ASCII_LF;
                        lf_pending <= 1'b0;
                        busy       <= 1'b1;
                    end else if (!empty && wrap_cond) begin
                        state      <= WRAP_CR;
                        prt_rdy    <= 1'b1;
                        prt_ascii  <= ASCII_CR;
                        col        <= '0;
                        lf_pending <= 1'b1;
                        busy       <= 1'b1;
                    end else
`endif
                    if (!empty) begin
                        state     <= ISSUE;
                        prt_rdy   <= 1'b1;
                        prt_ascii <= head;
                        col       <= col_next(col, head);
                        busy      <= 1'b1;
                    end
                end

`ifdef PRINT_SCHED_WRAP_EN
                ISSUE, WRAP_CR, WRAP_LF: begin
`else
                ISSUE: begin
`endif
                    prt_rdy <= 1'b0;
                    timer   <= '0;
                    busy    <= 1'b1;
                    state   <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (prt_done || timer == TW'(TIMEOUT-1)) begin
                        // An abandoned byte is not retried; the queue just moves on.
                        if (!prt_done) timeout_err <= 1'b1;
                        state <= IDLE;
`ifdef PRINT_SCHED_WRAP_EN
                        busy  <= !empty || push_ok || lf_pending;
`else
                        busy  <= !empty || push_ok;
`endif
                    end else begin
                        timer <= timer + TW'(1);
                        busy  <= 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    prt_rdy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_print_scheduler.sv
// Randomized and directed bench for print_scheduler against a queue-based printer model.
module tb_print_scheduler;
    localparam int DEPTH   = 4;
    localparam int LINE_W  = 4;
    localparam int TIMEOUT = 16;
`ifdef PRINT_SCHED_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       char_valid;
    logic [7:0] char_in;
    logic       prt_rdy;
    logic [7:0] prt_ascii;
    logic       prt_done;
    logic       busy;
    logic [2:0] fifo_count;
    logic [2:0] col;
    logic       overflow;
    logic       timeout_err;

    print_scheduler #(.DEPTH(DEPTH), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .char_valid  (char_valid),
        .char_in     (char_in),
        .prt_rdy     (prt_rdy),
        .prt_ascii   (prt_ascii),
        .prt_done    (prt_done),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .col         (col),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Printer model state and expected stream
    logic [7:0] got_q[$];
    int         rdy_q[$];
    logic [7:0] exp_q[$];
    int         mcol;
    int         push_cyc;
    bit         done_en, done_rand, early_done, force_done;
    int         done_dly;
    int         dcnt;

    function automatic bit printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    task automatic model_push(input logic [7:0] b);
        if (WRAP && printable(b) && mcol == LINE_W) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            mcol = 0;
        end
        exp_q.push_back(b);
        if (printable(b))                    mcol = (mcol < LINE_W) ? mcol + 1 : LINE_W;
        else if (b == 8'h0D || b == 8'h0A)   mcol = 0;
        else if (b == 8'h08)                 mcol = (mcol > 0) ? mcol - 1 : 0;
    endtask

    // Printer responder: captures each rdy and answers with done after a delay.
    initial begin
        prt_done = 1'b0;
        dcnt     = 0;
        forever begin
            @(negedge clk);
            prt_done = 1'b0;
            if (rst) dcnt = 0;
            else begin
                if (force_done) begin
                    prt_done   = 1'b1;
                    force_done = 1'b0;
                end
                if (dcnt > 0) begin
                    dcnt--;
                    if (dcnt == 0) prt_done = 1'b1;
                end
                if (prt_rdy) begin
                    got_q.push_back(prt_ascii);
                    rdy_q.push_back(cyc);
                    if (early_done) prt_done = 1'b1;
                    if (done_en) dcnt = done_rand ? int'($urandom_range(1, 6)) : done_dly;
                end
            end
        end
    end

    task automatic clear_model();
        got_q.delete();
        rdy_q.delete();
        exp_q.delete();
        mcol = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        char_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accept);
        char_valid = 1'b1;
        char_in    = b;
        push_cyc   = cyc;
        if (accept) model_push(b);
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((busy || dcnt > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_rdys(input string tag, input int cnt, input int budget);
        int n = 0;
        while (got_q.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, "_col"}, 32'(col), 32'(mcol));
    endtask

    initial begin
        int t0;
        logic [7:0] seq3 [4];
        rst = 1'b1; char_valid = 1'b0; char_in = '0;
        done_en = 1'b1; done_rand = 1'b0; early_done = 1'b0; force_done = 1'b0; done_dly = 10;
        clear_model();
        repeat (3) @(negedge clk);
        chk("rst_rdy", 32'(prt_rdy), 0);
        chk("rst_ascii", 32'(prt_ascii), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_col", 32'(col), 0);
        chk("rst_flags", 32'({overflow, timeout_err}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte: rdy two cycles after push, done ten cycles later.
        push_byte(8'h41, 1'b1);
        @(negedge clk);
        chk("t1_rdy", 32'(prt_rdy), 1);
        chk("t1_lat", 32'(cyc - push_cyc), 2);
        chk("t1_ascii", 32'(prt_ascii), 32'h41);
        @(negedge clk);
        chk("t1_rdy_pulse", 32'(prt_rdy), 0);
        repeat (9) @(negedge clk);
        chk("t1_busy_wait", 32'(busy), 1);
        @(negedge clk);
        chk("t1_busy_idle", 32'(busy), 0);
        chk("t1_col", 32'(col), 1);
        chk("t1_count", 32'(fifo_count), 0);
        check_stream("t1");

        // Fill past capacity while the printer is slow.
        do_reset();
        done_dly = 12;
        for (int i = 0; i < DEPTH + 1; i++) push_byte(8'h61 + 8'(i), 1'b1);
        chk("t2_full", 32'(fifo_count), DEPTH);
        chk("t2_no_ovf", 32'(overflow), 0);
        push_byte(8'h7A, 1'b0);
        chk("t2_ovf", 32'(overflow), 1);
        wait_idle("t2_drain", 500);
        check_stream("t2");
        for (int i = 1; i < rdy_q.size(); i++)
            chk("t2_gap", 32'(rdy_q[i] - rdy_q[i-1] >= done_dly + 2), 1);
        chk("t2_ovf_sticky", 32'(overflow), 1);

        // Column control bytes.
        do_reset();
        done_dly = 3;
        seq3[0] = 8'h08; seq3[1] = 8'h42; seq3[2] = 8'h08; seq3[3] = 8'h0D;
        for (int i = 0; i < 4; i++) begin
            push_byte(seq3[i], 1'b1);
            wait_idle("t3_drain", 100);
            chk("t3_col_step", 32'(col), 32'(mcol));
        end
        check_stream("t3");

        // Printer never answers; an early done on the rdy cycle must not count.
        do_reset();
        done_en = 1'b0; early_done = 1'b1;
        push_byte(8'h78, 1'b1);
        push_byte(8'h79, 1'b1);
        wait_rdys("t4_first", 1, 20);
        t0 = rdy_q[0];
        while (cyc < t0 + TIMEOUT) @(negedge clk);
        chk("t4_err_before", 32'(timeout_err), 0);
        @(negedge clk);
        chk("t4_err_set", 32'(timeout_err), 1);
        wait_rdys("t4_second", 2, 40);
        if (rdy_q.size() > 1) chk("t4_gap", 32'(rdy_q[1] - t0), TIMEOUT + 2);
        wait_idle("t4_drain", 100);
        check_stream("t4");

        // Reset mid-handshake with sticky flags set and bytes queued.
        early_done = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) push_byte(8'h30 + 8'(i), 1'b1);
        chk("t6_pre_ovf", 32'(overflow), 1);
        chk("t6_pre_busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rdy", 32'(prt_rdy), 0);
        chk("t6_ascii", 32'(prt_ascii), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_count", 32'(fifo_count), 0);
        chk("t6_col", 32'(col), 0);
        chk("t6_flags", 32'({overflow, timeout_err}), 0);
        rst = 1'b0;
        clear_model();
        force_done = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_no_rdy", 32'(got_q.size()), 0);
        chk("t6_idle", 32'(busy), 0);

        // Line wrap on "ABCDE".
        do_reset();
        done_en = 1'b1; done_dly = 3;
        push_byte(8'h41, 1'b1); push_byte(8'h42, 1'b1); push_byte(8'h43, 1'b1);
        push_byte(8'h44, 1'b1); push_byte(8'h45, 1'b1);
        wait_idle("t5_drain", 200);
        check_stream("t5");
        chk("t5_len_abs", 32'(got_q.size()), WRAP ? 7 : 5);
        chk("t5_col_abs", 32'(col), WRAP ? 1 : 4);

        // Randomized traffic with random printer delays.
        do_reset();
        done_rand = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo_count < 3'(DEPTH - 1)) begin
                int r = int'($urandom_range(0, 9));
                logic [7:0] b;
                if (r < 6)       b = 8'($urandom_range(32, 126));
                else if (r == 6) b = 8'h0D;
                else if (r == 7) b = 8'h0A;
                else if (r == 8) b = 8'h08;
                else             b = 8'($urandom_range(127, 255));
                push_byte(b, 1'b1);
            end else @(negedge clk);
        end
        wait_idle("t7_drain", 2000);
        check_stream("t7");
        chk("t7_flags", 32'({overflow, timeout_err}), 0);
        chk("t7_count", 32'(fifo_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
